switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Upstream input stage for the switch_value AXI4-Lite peripheral.
- Synchronises raw board switch inputs into ACLK and debounces each bit independently.
- Publishes a stable switch vector plus a sticky change mask and interrupt, which the AXI slave exposes as readable registers.
- The AXI slave returns an acknowledge pulse that clears the change mask.

Parameters:
- NUM_SW, 8, number of switch inputs (1..32).
- STABLE_CYCLES, 100000, consecutive ACLK cycles a synchronised bit must differ from its stable value before the stable value updates (1 ms at 100 MHz). Minimum 2.
- CNT_W, $clog2(STABLE_CYCLES), counter width; derived, do not override.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- sw_in  in  NUM_SW  raw asynchronous switch levels.
- sw_stable  out  NUM_SW  debounced switch vector.
- sw_changed  out  1  single-cycle pulse when any sw_stable bit updates.
- change_mask  out  NUM_SW  sticky; bit set when that sw_stable bit has toggled since the last acknowledge.
- irq  out  1  equals OR-reduction of change_mask (registered).
- event_ack  in  1  single-cycle pulse from the AXI slave; clears change_mask.

Behaviour:
- Reset: asynchronous and active-low. While ARESETN=0, all of the following are 0:
  - sync flops and counters;
  - sw_stable, sw_changed, change_mask, irq.
- Reset mid-debounce discards partial counts. After release, a switch held at 1 reaches sw_stable after the normal latency.
- Synchroniser: 2-FF per bit (sync1 then sync2). Call sync2 "synced".
- Per-bit debounce at every ACLK rising edge:
  - If synced == stable: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: stable <= synced and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: for a clean edge on sw_in meeting setup before edge N, sw_stable changes at edge N+STABLE_CYCLES+1, i.e. it is observed after STABLE_CYCLES+2 edges.
- Glitch rejection: a synced excursion shorter than STABLE_CYCLES cycles returns the counter to 0 and produces no output change.
- Bounce handling: any return of synced to the stable value restarts the count from 0.
- sw_changed: asserted during the first cycle the new sw_stable value is visible, for exactly 1 cycle. Multiple bits updating on the same edge still produce one pulse.
- change_mask, registered:
  - next = (event_ack ? 0 : change_mask) | update_vec.
  - update_vec is the per-bit stable-update strobe.
  - When ack and an update coincide, the newly updated bits remain set (set wins).
- irq: follows change_mask with 1 cycle latency (irq(t+1) = |change_mask(t)).
- event_ack while change_mask == 0 has no effect.
- Widths:
  - The counter never exceeds STABLE_CYCLES-1; there is no wrap.
  - Bits are fully independent; there is no cross-bit arbitration.

Decomposition:
- switch_debounce_pkg contains:
  - DEFAULT_NUM_SW = 8;
  - DEFAULT_STABLE_CYCLES = 100000;
  - function cnt_width(stable_cycles) returning $clog2.
- Sub-module sw_debounce_bit holds the 2-FF synchroniser, counter, stable flop and update strobe for one bit.
- switch_debounce instantiates NUM_SW copies via generate and implements the change_mask, sw_changed and irq logic.

Test Plan (NUM_SW=4, STABLE_CYCLES=4, ACLK 10 ns, ARESETN released at 200 ns):
1. Reset with sw_in=4'b1010 -> all outputs 0 during reset. After release, sw_stable=4'b1010 after exactly 6 edges, sw_changed pulses once, change_mask=4'b1010, irq=1 one cycle later.
2. sw_in[0] toggles 0 then 1 for 3 cycles, then back to 0 -> sw_stable[0] stays 0, no sw_changed pulse, change_mask unchanged.
3. sw_in[2] bounces 1,0,1,0,1 on consecutive cycles, then holds at 1 -> sw_stable[2] rises exactly 6 edges after the final 0-to-1 transition; one sw_changed pulse.
4. With change_mask=4'b0001, pulse event_ack on the same edge that bit 3 updates -> change_mask=4'b1000 and irq stays 1.
5. event_ack with no pending change -> change_mask=0, irq=0. Then pulse ARESETN low mid-count (cnt=2) and release with the input still toggled -> the full 6-edge latency is measured from release.
6. sw_in bits 1 and 3 change on the same cycle -> both sw_stable bits update on the same edge, a single 1-cycle sw_changed pulse, change_mask=4'b1010.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared defaults and width helper for the switch debounce stage.
// No logic here: constants and a width function only.
package switch_debounce_pkg;

  localparam int DEFAULT_NUM_SW        = 8;
  localparam int DEFAULT_STABLE_CYCLES = 100000;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, run-length counter, stable flop, update strobe.
// Latency STABLE_CYCLES+1 edges after the first sync stage captures; no backpressure.
module sw_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic sw_raw,
  output logic stable,
  output logic update
);

  localparam int               CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             synced;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  assign differ = (synced != stable);
  // Strobe is high on the edge that commits the new stable value.
  assign update = differ && (cnt == CNT_MAX);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1  <= sw_raw;
      synced <= sync1;
      if (!differ) begin
        cnt <= '0;
      end else if (update) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch vector with sticky change mask, change pulse and irq for the AXI slave.
// Latency STABLE_CYCLES+2 edges input-to-sw_stable; irq one edge after change_mask; no backpressure.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW        = DEFAULT_NUM_SW,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              sw_changed,
  output logic [NUM_SW-1:0] change_mask,
  output logic              irq,
  input  logic              event_ack
);

  logic [NUM_SW-1:0] update_vec;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .ACLK   (ACLK),
      .ARESETN(ARESETN),
      .sw_raw (sw_in[i]),
      .stable (sw_stable[i]),
      .update (update_vec[i])
    );
  end

  // Ack clears first, then fresh updates are OR-ed in so a coincident update survives.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      change_mask <= '0;
      sw_changed  <= 1'b0;
      irq         <= 1'b0;
    end else begin
      change_mask <= (event_ack ? '0 : change_mask) | update_vec;
      sw_changed  <= |update_vec;
      irq         <= |change_mask;
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce: window-based reference model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_switch_debounce;

  localparam int NUM_SW = 4;
  localparam int S      = 4;

  logic              ACLK;
  logic              ARESETN;
  logic [NUM_SW-1:0] sw_in;
  logic [NUM_SW-1:0] sw_stable;
  logic              sw_changed;
  logic [NUM_SW-1:0] change_mask;
  logic              irq;
  logic              event_ack;

  int checks   = 0;
  int failures = 0;
  int n_pulse  = 0;
  int p0;
  bit done     = 1'b0;

  switch_debounce #(
    .NUM_SW       (NUM_SW),
    .STABLE_CYCLES(S)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .sw_in      (sw_in),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .change_mask(change_mask),
    .irq        (irq),
    .event_ack  (event_ack)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Reference model: a bit commits when the input samples taken S+1..2 edges ago
  // (the values the synchroniser presents during the last S edges) all differ from it.
  logic [NUM_SW-1:0] hist [0:S];
  logic [NUM_SW-1:0] m_stable;
  logic [NUM_SW-1:0] m_mask;
  logic              m_changed;
  logic              m_irq;

  function automatic logic [NUM_SW-1:0] window_update();
    logic [NUM_SW-1:0] r;
    r = '1;
    for (int k = 1; k <= S; k++) r = r & (hist[k] ^ m_stable);
    return r;
  endfunction

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k <= S; k++) hist[k] <= '0;
      m_stable  <= '0;
      m_mask    <= '0;
      m_changed <= 1'b0;
      m_irq     <= 1'b0;
    end else begin
      m_stable  <= m_stable ^ window_update();
      m_changed <= |window_update();
      m_mask    <= (event_ack ? '0 : m_mask) | window_update();
      m_irq     <= |m_mask;
      hist[0]   <= sw_in;
      for (int k = 1; k <= S; k++) hist[k] <= hist[k-1];
    end
  end

  always @(negedge ACLK) begin
    if (!done) begin
      checks++;
      if ({sw_stable, sw_changed, change_mask, irq} !== {m_stable, m_changed, m_mask, m_irq}) begin
        failures++;
        $display("FAIL model_cmp t=%0t: got stable=%b chg=%b mask=%b irq=%b, expected stable=%b chg=%b mask=%b irq=%b",
                 $time, sw_stable, sw_changed, change_mask, irq, m_stable, m_changed, m_mask, m_irq);
      end
      if (sw_changed === 1'b1) n_pulse++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETN   = 1'b0;
    sw_in     = 4'b1010;
    event_ack = 1'b0;

    // 1: reset state, then first-settle latency from release
    #150;
    check("rst_stable",  32'(sw_stable),   'h0);
    check("rst_changed", 32'(sw_changed),  'h0);
    check("rst_mask",    32'(change_mask), 'h0);
    check("rst_irq",     32'(irq),         'h0);
    #50 ARESETN = 1'b1;
    edges(5);
    check("t1_stable_e5", 32'(sw_stable),   'b0000);
    check("t1_mask_e5",   32'(change_mask), 'b0000);
    edges(1);
    check("t1_stable_e6",  32'(sw_stable),   'b1010);
    check("t1_changed_e6", 32'(sw_changed),  'h1);
    check("t1_mask_e6",    32'(change_mask), 'b1010);
    check("t1_irq_e6",     32'(irq),         'h0);
    edges(1);
    check("t1_irq_e7",     32'(irq),        'h1);
    check("t1_changed_e7", 32'(sw_changed), 'h0);
    check("t1_pulses",     32'(n_pulse),    'h1);

    // 2: 3-cycle glitch on bit 0 is rejected
    p0 = n_pulse;
    sw_in = 4'b1011;
    edges(3);
    sw_in = 4'b1010;
    edges(8);
    check("t2_stable", 32'(sw_stable),    'b1010);
    check("t2_mask",   32'(change_mask),  'b1010);
    check("t2_pulses", 32'(n_pulse - p0), 'h0);

    // 3: bounce on bit 2, latency counted from the final rising transition
    p0 = n_pulse;
    sw_in[2] = 1'b1; edges(1);
    sw_in[2] = 1'b0; edges(1);
    sw_in[2] = 1'b1; edges(1);
    sw_in[2] = 1'b0; edges(1);
    sw_in[2] = 1'b1;
    edges(5);
    check("t3_stable_e5", 32'(sw_stable), 'b1010);
    edges(1);
    check("t3_stable_e6",  32'(sw_stable),   'b1110);
    check("t3_changed_e6", 32'(sw_changed),  'h1);
    check("t3_mask",       32'(change_mask), 'b1110);
    edges(1);
    check("t3_pulses", 32'(n_pulse - p0), 'h1);

    // 4: ack coinciding with an update keeps the new bit
    event_ack = 1'b1; edges(1); event_ack = 1'b0;
    check("t4_mask_clr", 32'(change_mask), 'h0);
    edges(1);
    check("t4_irq_clr", 32'(irq), 'h0);
    sw_in = 4'b1111;
    edges(6);
    check("t4_stable_b0", 32'(sw_stable),   'b1111);
    check("t4_mask_b0",   32'(change_mask), 'b0001);
    edges(1);
    check("t4_irq_b0", 32'(irq), 'h1);
    sw_in = 4'b0111;
    edges(5);
    event_ack = 1'b1; edges(1); event_ack = 1'b0;
    check("t4_stable_b3", 32'(sw_stable),   'b0111);
    check("t4_mask_set",  32'(change_mask), 'b1000);
    check("t4_irq_same",  32'(irq),         'h1);
    edges(1);
    check("t4_irq_hold", 32'(irq), 'h1);

    // 5: idle ack, then reset mid-count discards the partial run
    event_ack = 1'b1; edges(1); event_ack = 1'b0;
    check("t5_mask_clr", 32'(change_mask), 'h0);
    edges(1);
    event_ack = 1'b1; edges(1); event_ack = 1'b0;
    check("t5_idle_mask", 32'(change_mask), 'h0);
    check("t5_idle_irq",  32'(irq),         'h0);
    sw_in = 4'b0101;
    edges(4);
    ARESETN = 1'b0;
    #2;
    check("t5_rst_stable", 32'(sw_stable),   'h0);
    check("t5_rst_mask",   32'(change_mask), 'h0);
    edges(2);
    ARESETN = 1'b1;
    edges(5);
    check("t5_stable_e5", 32'(sw_stable), 'b0000);
    edges(1);
    check("t5_stable_e6",  32'(sw_stable),   'b0101);
    check("t5_changed_e6", 32'(sw_changed),  'h1);
    check("t5_mask_e6",    32'(change_mask), 'b0101);

    // 6: two bits change together -> one edge, one pulse
    event_ack = 1'b1; edges(1); event_ack = 1'b0;
    p0 = n_pulse;
    sw_in = 4'b1111;
    edges(5);
    check("t6_stable_e5", 32'(sw_stable), 'b0101);
    edges(1);
    check("t6_stable_e6",  32'(sw_stable),   'b1111);
    check("t6_changed_e6", 32'(sw_changed),  'h1);
    check("t6_mask",       32'(change_mask), 'b1010);
    edges(1);
    check("t6_changed_e7", 32'(sw_changed),   'h0);
    check("t6_pulses",     32'(n_pulse - p0), 'h1);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
